// File: rtl/divider_arb_if.sv
// Requester, flush and divider-side signals of divider_arb, bundled for port connection.
interface divider_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned M    = 4,
  parameter int unsigned Q_W  = 5
);
  logic [NREQ-1:0]   req;
  logic [NREQ*M-1:0] req_divisor;
  logic [NREQ-1:0]   gnt;
  logic              flush_req;
  logic              flush_done;
  logic              busy;
  logic [M-1:0]      div_divisor;
  logic [Q_W-1:0]    div_merchant;
  logic [M-1:0]      div_remainder;
  logic [NREQ-1:0]   rsp_valid;
  logic [Q_W-1:0]    rsp_merchant;
  logic [M-1:0]      rsp_remainder;
  logic              rsp_err;

  modport slave (
    input  req, req_divisor, flush_req, div_merchant, div_remainder,
    output gnt, flush_done, busy, div_divisor,
           rsp_valid, rsp_merchant, rsp_remainder, rsp_err
  );

  modport master (
    output req, req_divisor, flush_req, div_merchant, div_remainder,
    input  gnt, flush_done, busy, div_divisor,
           rsp_valid, rsp_merchant, rsp_remainder, rsp_err
  );
endinterface

// File: rtl/divider_arb.sv
// Round-robin scheduler for one shared pipelined constant-dividend divider; a tag pipe routes
// each result back to its requester. Define DIV_ARB_ZERO_CHK_EN to reject divisors below 2.
module divider_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned M    = 4,
  parameter int unsigned Q_W  = 5,
  parameter int unsigned LAT  = 5
) (
  input  logic         clk,
  input  logic         rstn,
  divider_arb_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [LAT-1:0]          tag_err_q, tag_err_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [Q_W-1:0]          rsp_merchant_q, rsp_merchant_d;
  logic [M-1:0]            rsp_remainder_q, rsp_remainder_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    flush_done_q, flush_done_d;

  logic                    grant_en;
  logic                    gnt_any;
  logic                    gnt_err;
  logic                    pipe_empty;
  logic [IDW-1:0]          gnt_id;
  logic [NREQ-1:0]         gnt;
  logic [M-1:0]            gnt_div;
  logic [M-1:0]            div_divisor;
  int unsigned             scan_idx;

  assign pipe_empty = ~|tag_vld_q;
  // Grants are masked while rstn is low so gnt reads 0 throughout reset.
  assign grant_en   = rstn && (state_q != DRAIN);

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = 0;
    if (grant_en) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        scan_idx = (32'(ptr_q) + i) % NREQ;
        if (!gnt_any && bus.req[scan_idx[IDW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt     = gnt_any ? (NREQ'(1) << gnt_id) : '0;
    gnt_div = bus.req_divisor[gnt_id*M +: M];
`ifdef DIV_ARB_ZERO_CHK_EN
    gnt_err = gnt_any && (gnt_div < M'(2));
`else
    gnt_err = 1'b0;
`endif
    if (!gnt_any) begin
      div_divisor = '0;
    end else if (gnt_err) begin
      div_divisor = '1;
    end else begin
      div_divisor = gnt_div;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Tag pipe mirrors the divider stages; entry LAT-1 lines up with the divider output.
  always_comb begin
    tag_vld_d = {tag_vld_q[LAT-2:0], gnt_any};
    tag_id_d  = {tag_id_q[LAT-2:0], gnt_id};
    tag_err_d = {tag_err_q[LAT-2:0], gnt_err};
  end

  always_comb begin
    rsp_valid_d     = '0;
    rsp_merchant_d  = rsp_merchant_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_err_d       = 1'b0;
    if (tag_vld_q[LAT-1]) begin
      rsp_valid_d = NREQ'(1) << tag_id_q[LAT-1];
      if (tag_err_q[LAT-1]) begin
        rsp_merchant_d  = '1;
        rsp_remainder_d = '0;
        rsp_err_d       = 1'b1;
      end else begin
        rsp_merchant_d  = bus.div_merchant;
        rsp_remainder_d = bus.div_remainder;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = bus.flush_req ? DRAIN : RUN;
        end else if (bus.flush_req) begin
          flush_done_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush_req) begin
          state_d = DRAIN;
        end else if (!gnt_any && pipe_empty) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      tag_vld_q       <= '0;
      tag_id_q        <= '0;
      tag_err_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_merchant_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_err_q       <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      tag_vld_q       <= tag_vld_d;
      tag_id_q        <= tag_id_d;
      tag_err_q       <= tag_err_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_merchant_q  <= rsp_merchant_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_err_q       <= rsp_err_d;
      flush_done_q    <= flush_done_d;
    end
  end

  assign bus.gnt           = gnt;
  assign bus.div_divisor   = div_divisor;
  assign bus.flush_done    = flush_done_q;
  assign bus.busy          = ~pipe_empty | (state_q == DRAIN);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_merchant  = rsp_merchant_q;
  assign bus.rsp_remainder = rsp_remainder_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule
